stopwatch_ctrl: RTL and testbench

//  Sequencing controller for the stopwatch datapath (BCD counter, lap freeze

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/stopwatch_ctrl.sv | 102 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encodings and default timing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStop = 2'b10
  } state_e;

  localparam int unsigned DefTickDiv  = 120000;
  localparam int unsigned DefDbCycles = 60000;
  localparam int unsigned DefLapTicks = 200;
  localparam int unsigned LapW        = 8;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button, filters bounce and emits a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 60000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Count only while the synchronised level disagrees with the accepted one.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button debounce, IDLE/RUN/STOP FSM, centisecond tick and lap freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DefTickDiv,
  parameter int unsigned DB_CYCLES = DefDbCycles,
  parameter int unsigned LAP_TICKS = DefLapTicks
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       tick,
  output logic       count_en,
  output logic       count_clr,
  output logic       freeze_load,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  logic start_p, stop_p, lap_p, clear_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .CLK(CLK), .RST_N(RST_N), .raw(btn_start), .press(start_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .CLK(CLK), .RST_N(RST_N), .raw(btn_stop), .press(stop_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .CLK(CLK), .RST_N(RST_N), .raw(btn_lap), .press(lap_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .CLK(CLK), .RST_N(RST_N), .raw(btn_clear), .press(clear_p)
  );

  logic [TW-1:0]   tick_cnt_q;
  logic [LapW-1:0] lap_q, lap_d;
  state_e          state_q, state_d;
  logic            tick_q, count_en_q, count_clr_q, freeze_load_q, freeze_q;
  logic            tick_wrap, clr_d, fl_d;

  assign tick_wrap = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Clear beats stop beats start beats lap; lap is only honoured in RUN.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    fl_d    = 1'b0;
    if (tick_wrap && (lap_q != '0)) lap_d = lap_q - LapW'(1);
    if (!(state_q inside {StIdle, StRun, StStop})) begin
      state_d = StIdle;
    end else if (clear_p) begin
      state_d = StIdle;
      clr_d   = 1'b1;
      lap_d   = '0;
    end else if (state_q == StRun) begin
      if (stop_p) begin
        state_d = StStop;
      end else if (lap_p) begin
        fl_d  = 1'b1;
        lap_d = LapW'(LAP_TICKS);
      end
    end else if (start_p) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt_q    <= '0;
      lap_q         <= '0;
      state_q       <= StIdle;
      tick_q        <= 1'b0;
      count_en_q    <= 1'b0;
      count_clr_q   <= 1'b0;
      freeze_load_q <= 1'b0;
      freeze_q      <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_wrap ? '0 : tick_cnt_q + TW'(1);
      lap_q         <= lap_d;
      state_q       <= state_d;
      tick_q        <= tick_wrap;
      count_en_q    <= tick_wrap && (state_d == StRun);
      count_clr_q   <= clr_d;
      freeze_load_q <= fl_d;
      freeze_q      <= (lap_d != '0);
    end
  end

  assign tick        = tick_q;
  assign count_en    = count_en_q;
  assign count_clr   = count_clr_q;
  assign freeze_load = freeze_load_q;
  assign freeze      = freeze_q;
  assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short timing parameters.
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 10;
  localparam int unsigned DB = 4;
  localparam int unsigned LT = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic       tick, count_en, count_clr, freeze_load, freeze;
  logic [1:0] state;

  always #5 CLK = ~CLK;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .LAP_TICKS(LT)) dut (
    .CLK(CLK), .RST_N(RST_N), .btn_start(btn_start), .btn_stop(btn_stop), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .tick(tick), .count_en(count_en), .count_clr(count_clr),
    .freeze_load(freeze_load), .freeze(freeze), .state(state)
  );

  int compared = 0;
  int mismatched = 0;
  int n_fl = 0, n_clr = 0;

  typedef struct {
    string      name;
    logic [3:0] btns;       // {clear, lap, stop, start}
    logic [1:0] exp_state;
    int         exp_fl;
    int         exp_clr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_clear, btn_lap, btn_stop, btn_start} = b;
  endtask

  task automatic press(input logic [3:0] b);
    set_btns(b);
    step(12);
    set_btns(4'b0000);
    step(10);
  endtask

  // Waits for freeze_load; reports whether freeze stayed high while waiting.
  task automatic wait_load(input string name, output logic fz_ok);
    logic got;
    got   = 1'b0;
    fz_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (freeze_load) begin
        got = 1'b1;
        break;
      end
      if (!freeze) fz_ok = 1'b0;
    end
    check(name, got, 1'b1);
    check({name, "_freeze"}, freeze, 1'b1);
  endtask

  task automatic window(input string name);
    int   k;
    logic fell, ft;
    k = 0; fell = 1'b0; ft = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tick) k++;
      if (!freeze) begin
        fell = 1'b1;
        ft   = tick;
        break;
      end
    end
    check({name, "_fell"}, fell, 1'b1);
    check({name, "_ticks"}, k, LT);
    check({name, "_fall_on_tick"}, ft, 1'b1);
  endtask

  // count_en must coincide exactly with tick while RUN is shown.
  always @(negedge CLK) begin
    if (RST_N) begin
      n_fl  += int'(freeze_load);
      n_clr += int'(count_clr);
      compared++;
      if (count_en !== (tick && (state == 2'b01))) begin
        mismatched++;
        $display("FAIL count_en_invariant: got %b expected %b (state %b)", count_en,
                 tick && (state == 2'b01), state);
      end
    end
  end

  initial begin
    int   lat, k, ce, f0, c0;
    logic got, fz_ok, prev;

    vecs[0]  = '{"start",        4'b0001, 2'b01, 0, 0};
    vecs[1]  = '{"stop_start",   4'b0011, 2'b10, 0, 0};
    vecs[2]  = '{"restart",      4'b0001, 2'b01, 0, 0};
    vecs[3]  = '{"clear_start",  4'b1001, 2'b00, 0, 1};
    vecs[4]  = '{"start2",       4'b0001, 2'b01, 0, 0};
    vecs[5]  = '{"stop_lap",     4'b0110, 2'b10, 0, 0};
    vecs[6]  = '{"lap_in_stop",  4'b0100, 2'b10, 0, 0};
    vecs[7]  = '{"start3",       4'b0001, 2'b01, 0, 0};
    vecs[8]  = '{"lap_in_run",   4'b0100, 2'b01, 1, 0};
    vecs[9]  = '{"stop",         4'b0010, 2'b10, 0, 0};
    vecs[10] = '{"stop_in_stop", 4'b0010, 2'b10, 0, 0};
    vecs[11] = '{"start_lap",    4'b0101, 2'b01, 0, 0};
    vecs[12] = '{"clear",        4'b1000, 2'b00, 0, 1};
    vecs[13] = '{"stop_in_idle", 4'b0010, 2'b00, 0, 0};
    vecs[14] = '{"lap_in_idle",  4'b0100, 2'b00, 0, 0};

    #1 RST_N = 1'b0;
    #2 check("reset_outputs", {tick, count_en, count_clr, freeze_load, freeze, state}, 0);
    @(negedge CLK) RST_N = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (tick) begin
        lat = i;
        break;
      end
    end
    check("first_tick_latency", lat, TD);
    check("state_after_reset", state, 2'b00);

    // Start latency and count_en on every tick in RUN.
    btn_start = 1'b1;
    step(DB + 2);
    check("start_lat_early", state, 2'b00);
    step(1);
    check("start_lat_exact", state, 2'b01);
    k = 0; ce = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      step(1);
      k  += int'(tick);
      ce += int'(count_en);
    end
    check("run_ticks", k, 5);
    check("run_count_en", ce, 5);
    btn_start = 1'b0;
    step(10);
    press(4'b1000);
    check("clear_to_idle", state, 2'b00);

    // Bouncing start never qualifies.
    for (int i = 0; i < 15; i++) begin
      btn_start = ~btn_start;
      step(2);
    end
    btn_start = 1'b0;
    step(20);
    check("bounce_state", state, 2'b00);

    for (int i = 0; i < 15; i++) begin
      f0 = n_fl; c0 = n_clr;
      press(vecs[i].btns);
      check({vecs[i].name, "_state"}, state, vecs[i].exp_state);
      check({vecs[i].name, "_freeze_load"}, n_fl - f0, vecs[i].exp_fl);
      check({vecs[i].name, "_count_clr"}, n_clr - c0, vecs[i].exp_clr);
    end

    // Lap window, then a lap that retriggers during an active freeze.
    press(4'b0001);
    step(4 * TD);
    f0 = n_fl;
    btn_lap = 1'b1;
    wait_load("lap1_load", fz_ok);
    btn_lap = 1'b0;
    window("lap1_window");
    check("lap1_load_count", n_fl - f0, 1);
    btn_lap = 1'b1;
    wait_load("lap2_load", fz_ok);
    btn_lap = 1'b0;
    step(8);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick) begin
        got = 1'b1;
        break;
      end
    end
    check("lap2_tick_seen", got, 1'b1);
    btn_lap = 1'b1;
    wait_load("lap3_reload", fz_ok);
    check("lap3_freeze_held", fz_ok, 1'b1);
    btn_lap = 1'b0;
    window("lap3_window");

    // Clear during an active freeze.
    btn_lap = 1'b1;
    wait_load("lap4_load", fz_ok);
    btn_lap = 1'b0;
    step(8);
    btn_clear = 1'b1;
    got = 1'b0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev = freeze;
      step(1);
      if (count_clr) begin
        got = 1'b1;
        break;
      end
    end
    check("clr_seen", got, 1'b1);
    check("clr_freeze_before", prev, 1'b1);
    check("clr_freeze_drop", freeze, 1'b0);
    check("clr_state", state, 2'b00);
    btn_clear = 1'b0;
    step(10);

    // Asynchronous reset while running with freeze high.
    press(4'b0001);
    btn_lap = 1'b1;
    wait_load("lap5_load", fz_ok);
    step(2);
    check("pre_reset_run", {freeze, state}, 3'b101);
    #1 RST_N = 1'b0;
    #1 check("async_reset_outputs", {tick, count_en, count_clr, freeze_load, freeze, state}, 0);
    btn_lap = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (tick) begin
        lat = i;
        break;
      end
    end
    check("reset2_tick_latency", lat, TD);
    check("reset2_state", {freeze, state}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
